// File: rtl/apb_master_pkg.sv
// Shared FSM encoding and default bus widths for the APB master sequencer.
package apb_master_pkg;

    localparam int APB_ADDR_W = 12;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_wait_timeout.sv
// ACCESS-phase watchdog: counts wait cycles and flags the edge on which the
// count reaches TIMEOUT_CYCLES.
module apb_wait_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the wait cycle whose edge takes the count to the terminal value.
    assign expired = count_en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_timer_master.sv
// APB master sequencer driving the timer slave port from a valid/ready command
// interface. Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
module apb_timer_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_slverr,
    output logic                tim_psel,
    output logic                tim_penable,
    output logic                tim_pwrite,
    output logic [ADDR_W-1:0]   tim_paddr,
    output logic [DATA_W-1:0]   tim_pwdata,
    output logic [DATA_W/8-1:0] tim_pstrb,
    input  logic                tim_pready,
    input  logic [DATA_W-1:0]   tim_prdata,
    input  logic                tim_pslverr
);

    localparam int STRB_W = DATA_W / 8;

    apb_state_e          state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_slverr_q, rsp_slverr_d;
    logic                timeout_hit;

`ifdef APB_TIMEOUT_EN
    apb_wait_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (state_q == SETUP),
        .count_en((state_q == ACCESS) && !tim_pready),
        .expired (timeout_hit)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = req_write;
                    paddr_d   = req_addr;
                    pwdata_d  = req_wdata;
                    pstrb_d   = req_write ? req_strb : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // pready takes priority over a timeout landing on the same edge.
                if (tim_pready) begin
                    state_d      = RESP;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    pstrb_d      = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = pwrite_q ? '0 : tim_prdata;
                    rsp_slverr_d = tim_pslverr;
                end else if (timeout_hit) begin
                    state_d      = RESP;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    pstrb_d      = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = '0;
                    rsp_slverr_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
        end
    end

    assign req_ready   = (state_q == IDLE) && !sys_rst;
    assign tim_psel    = psel_q;
    assign tim_penable = penable_q;
    assign tim_pwrite  = pwrite_q;
    assign tim_paddr   = paddr_q;
    assign tim_pwdata  = pwdata_q;
    assign tim_pstrb   = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;

endmodule

// File: tb/tb_apb_timer_master.sv
// Directed bench for apb_timer_master; timeout scenarios run when APB_TIMEOUT_EN is defined.
module tb_apb_timer_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        tim_psel, tim_penable, tim_pwrite;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic        tim_pready = 1'b0;
    logic [31:0] tim_prdata = '0;
    logic        tim_pslverr = 1'b0;

    int checks = 0;
    int failures = 0;

    apb_timer_master #(
        .ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .sys_clk(clk), .sys_rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr),
        .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
        .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
        .tim_pready(tim_pready), .tim_prdata(tim_prdata), .tim_pslverr(tim_pslverr)
    );

    always #5 clk = ~clk;

    // {psel, penable, pwrite, paddr, pwdata, pstrb} and {valid, slverr, rdata}
    wire [50:0] bus = {tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb};
    wire [33:0] rsp = {rsp_valid, rsp_slverr, rsp_rdata};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus !== 51'd0 || rsp !== 34'd0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state bus=%h rsp=%h req_ready=%b required all 0", bus, rsp, req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b required=1", req_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        logic [50:0] exp_bus;
        tim_pready = 1'b1; tim_prdata = 32'hDEAD_BEEF; rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h004;
        req_wdata = 32'h0000_0001; req_strb = 4'hF;
        tick();
        req_valid = 1'b0;
        exp_bus = {1'b1, 1'b0, 1'b1, 12'h004, 32'h0000_0001, 4'hF};
        checks++;
        if (bus !== exp_bus || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_setup bus=%h rdy=%b rv=%b required bus=%h rdy=0 rv=0", bus, req_ready, rsp_valid, exp_bus);
        end
        tick();
        exp_bus = {1'b1, 1'b1, 1'b1, 12'h004, 32'h0000_0001, 4'hF};
        checks++;
        if (bus !== exp_bus || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_access bus=%h rv=%b required bus=%h rv=0", bus, rsp_valid, exp_bus);
        end
        tick();
        exp_bus = {1'b0, 1'b0, 1'b1, 12'h004, 32'h0000_0001, 4'h0};
        checks++;
        if (bus !== exp_bus || rsp !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL wr_resp bus=%h rsp=%h required bus=%h rsp=%h", bus, rsp, exp_bus, {1'b1, 1'b0, 32'h0});
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_done rv=%b rdy=%b required rv=0 rdy=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_read_wait();
        logic [50:0] exp_bus;
        tim_pready = 1'b0; tim_prdata = 32'hCAFE_0123; rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h010;
        req_wdata = 32'h5555_AAAA; req_strb = 4'hF;
        tick();
        req_valid = 1'b0;
        exp_bus = {1'b1, 1'b0, 1'b0, 12'h010, 32'h5555_AAAA, 4'h0};
        checks++;
        if (bus !== exp_bus) begin
            failures++;
            $display("FAIL rd_setup bus=%h required=%h", bus, exp_bus);
        end
        tick();
        exp_bus = {1'b1, 1'b1, 1'b0, 12'h010, 32'h5555_AAAA, 4'h0};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus !== exp_bus || rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rd_wait%0d bus=%h rv=%b required bus=%h rv=0", i, bus, rsp_valid, exp_bus);
            end
            tick();
        end
        tim_pready = 1'b1;
        checks++;
        if (bus !== exp_bus || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_last_access bus=%h rv=%b required bus=%h rv=0", bus, rsp_valid, exp_bus);
        end
        tick();
        checks++;
        if (rsp !== {1'b1, 1'b0, 32'hCAFE_0123} || tim_psel !== 1'b0 || tim_pstrb !== 4'h0) begin
            failures++;
            $display("FAIL rd_resp rsp=%h psel=%b pstrb=%h required rsp=%h psel=0 pstrb=0", rsp, tim_psel, tim_pstrb, {1'b1, 1'b0, 32'hCAFE_0123});
        end
        tick();
    endtask

    task automatic test_slverr_backpressure();
        tim_pready = 1'b1; tim_pslverr = 1'b1; rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h008;
        req_wdata = 32'h1234_5678; req_strb = 4'h3;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tim_pslverr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp !== {1'b1, 1'b1, 32'h0} || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL err_hold%0d rsp=%h rdy=%b required rsp=%h rdy=0", i, rsp, req_ready, {1'b1, 1'b1, 32'h0});
            end
            if (i < 4) tick();
        end
        rsp_ready = 1'b1;
        tim_prdata = 32'h0BAD_F00D;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h00C;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || tim_psel !== 1'b0) begin
            failures++;
            $display("FAIL err_release rv=%b rdy=%b psel=%b required 0/1/0", rsp_valid, req_ready, tim_psel);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (tim_psel !== 1'b1 || tim_paddr !== 12'h00C || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL next_accept psel=%b paddr=%h rdy=%b required 1/00c/0", tim_psel, tim_paddr, req_ready);
        end
        tick();
        tick();
        checks++;
        if (rsp !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
            failures++;
            $display("FAIL next_resp rsp=%h required=%h", rsp, {1'b1, 1'b0, 32'h0BAD_F00D});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int acc;
        int rv_cnt;
        int acc_cyc[3];
        logic took;
        acc = 0; rv_cnt = 0;
        tim_pready = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_strb = 4'hF;
        req_addr = 12'h020; req_wdata = 32'h0000_0020;
        for (int c = 0; c < 12 && acc < 3; c++) begin
            took = req_ready;
            tick();
            if (rsp_valid === 1'b1) rv_cnt++;
            if (took) begin
                acc_cyc[acc] = c;
                checks++;
                if (tim_paddr !== 12'h020 + 12'(4 * acc) || tim_psel !== 1'b1 || tim_penable !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_setup%0d paddr=%h psel=%b pen=%b required paddr=%h 1/0", acc, tim_paddr, tim_psel, tim_penable, 12'h020 + 12'(4 * acc));
                end
                acc++;
                if (acc < 3) begin
                    req_addr = 12'h020 + 12'(4 * acc);
                    req_wdata = 32'h20 + 32'(4 * acc);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            tick();
            if (rsp_valid === 1'b1) rv_cnt++;
        end
        checks++;
        if (acc !== 3 || acc_cyc[0] !== 0 || acc_cyc[1] !== 4 || acc_cyc[2] !== 8) begin
            failures++;
            $display("FAIL b2b_spacing accepted=%0d at %0d,%0d,%0d required 3 at 0,4,8", acc, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        checks++;
        if (rv_cnt !== 3) begin
            failures++;
            $display("FAIL b2b_responses got=%0d required=3", rv_cnt);
        end
    endtask

    task automatic test_reset_access();
        tim_pready = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h030;
        req_wdata = 32'hA5A5_A5A5; req_strb = 4'hC;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (tim_psel !== 1'b1 || tim_penable !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_access psel=%b pen=%b required 1/1", tim_psel, tim_penable);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus !== 51'd0 || rsp !== 34'd0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid bus=%h rsp=%h rdy=%b required all 0", bus, rsp, req_ready);
        end
        rst = 1'b0;
        tim_pready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || tim_psel !== 1'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL rst_after%0d rv=%b psel=%b rdy=%b required 0/0/1", i, rsp_valid, tim_psel, req_ready);
            end
        end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        tim_pready = 1'b0; tim_prdata = 32'h7777_7777; rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h014;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tim_psel !== 1'b1 || tim_penable !== 1'b1 || rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL to_wait%0d psel=%b pen=%b rv=%b required 1/1/0", i, tim_psel, tim_penable, rsp_valid);
            end
        end
        tick();
        checks++;
        if (rsp !== {1'b1, 1'b1, 32'h0} || tim_psel !== 1'b0 || tim_penable !== 1'b0) begin
            failures++;
            $display("FAIL to_abort rsp=%h psel=%b pen=%b required rsp=%h 0/0", rsp, tim_psel, tim_penable, {1'b1, 1'b1, 32'h0});
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        tim_pready = 1'b1;
        tick();
        checks++;
        if (rsp !== {1'b1, 1'b0, 32'h7777_7777}) begin
            failures++;
            $display("FAIL to_pready_wins rsp=%h required=%h", rsp, {1'b1, 1'b0, 32'h7777_7777});
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr_backpressure();
        test_back_to_back();
        test_reset_access();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_timer_master.md
Name: apb_timer_master

Overview:
- APB master sequencer directly upstream of the 64-bit timer's APB slave port; drives the tim_* bus signals into the timer top.
- Accepts single read/write requests from a local command interface (valid/ready).
- Runs the APB SETUP and ACCESS phases and waits on tim_pready.
- Returns read data and slave error on a response interface (valid/ready).

Parameters:
- ADDR_W, 12, APB address width (matches timer paddr)
- DATA_W, 32, APB data width
- TIMEOUT_CYCLES, 16, max ACCESS-phase cycles before abort (used only with APB_TIMEOUT_EN)

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  target register address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  byte strobes for writes
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_slverr  out  1  slave error (or timeout) for the transaction
- tim_psel  out  1  APB select
- tim_penable  out  1  APB enable
- tim_pwrite  out  1  APB direction
- tim_paddr  out  ADDR_W  APB address
- tim_pwdata  out  DATA_W  APB write data
- tim_pstrb  out  DATA_W/8  APB strobes; forced 0 on reads
- tim_pready  in  1  slave ready
- tim_prdata  in  DATA_W  slave read data
- tim_pslverr  in  1  slave error, valid with tim_pready in ACCESS

Behaviour:
- Reset: sys_clk and a synchronous, active-high sys_rst. While sys_rst is high at a clock edge, the FSM goes to IDLE.
  - Reset values: tim_psel=0, tim_penable=0, tim_pwrite=0, tim_paddr=0, tim_pwdata=0, tim_pstrb=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0.
- Registered outputs: all outputs are registered except req_ready, which is req_ready = (state==IDLE) && !sys_rst.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On req_valid, latch the request into tim_paddr, tim_pwrite and tim_pwdata.
  - tim_pstrb = req_strb if write, else 0.
  - Go to SETUP; tim_psel=1, tim_penable=0.
- SETUP: exactly one cycle; go to ACCESS; tim_penable=1.
- ACCESS:
  - Hold all bus signals stable until tim_pready=1.
  - On that edge: tim_psel=0, tim_penable=0.
  - rsp_rdata = tim_prdata for reads, 0 for writes; rsp_slverr = tim_pslverr.
  - rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_* until rsp_ready=1, then rsp_valid=0 and go to IDLE.
  - rsp_valid and rsp_ready may both be high on the first RESP cycle.
- Latency: request accepted at edge N.
  - SETUP visible N..N+1; ACCESS from N+1.
  - With zero-wait tim_pready, rsp_valid is high after edge N+2.
  - Minimum 4 cycles per transaction with rsp_ready tied high.
- Pipelining: no overlapping transactions; req_ready=0 in SETUP, ACCESS and RESP.
- Data stability: tim_paddr, tim_pwrite, tim_pwdata and tim_pstrb are unchanged from SETUP through the end of ACCESS.
- Bus idle values: after completion, tim_paddr and tim_pwdata keep their last values; tim_pstrb returns to 0.
- Reset mid-transaction: any state goes to IDLE on the reset edge; psel/penable drop; no response is produced; rsp_valid=0.
- Error field: tim_pslverr is ignored outside ACCESS-with-pready.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on SETUP and increments each ACCESS cycle without tim_pready.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: psel/penable drop, rsp_slverr=1, rsp_rdata=0, go to RESP.
  - If tim_pready arrives on the same edge as the terminal count, pready wins (normal completion).
- Not defined: no counter; ACCESS waits indefinitely.

Decomposition:
- Shared package/header apb_master_pkg:
  - FSM state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3)
  - default ADDR_W/DATA_W constants.
- Sub-module apb_wait_timeout: the timeout counter, instantiated only under APB_TIMEOUT_EN; ports clear, count_en, expired.

Test Plan:
- Write with zero-wait slave:
  - Stimulus: req addr=12'h004, wdata=32'h0000_0001, strb=4'hF, pready tied 1.
  - Response: psel high 2 cycles, penable 1 cycle, pstrb=4'hF; rsp_valid with slverr=0, rdata=0 after 3 edges.
- Read with 3 wait states:
  - Stimulus: addr=12'h010; pready low 3 ACCESS cycles then high with prdata=32'hCAFE_0123.
  - Response: rsp_rdata=32'hCAFE_0123; pstrb=0 throughout; bus signals stable across all waits.
- Slave error and response backpressure:
  - Stimulus: write with pslverr=1 at pready; rsp_ready low 5 cycles.
  - Response: rsp_valid/slverr held 5 cycles; req_ready=0 until rsp accepted; next request accepted the cycle after.
- Back-to-back:
  - Stimulus: req_valid held high for 3 requests, rsp_ready=1, zero-wait slave.
  - Response: one transaction every 4 cycles; no SETUP overlaps ACCESS.
- Reset in ACCESS:
  - Stimulus: sys_rst pulsed while pready=0.
  - Response: psel=penable=0 after that edge; rsp_valid never asserts; all outputs at reset values.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4:
  - Stimulus: pready stuck 0.
  - Response: abort after 4 ACCESS cycles, rsp_slverr=1, rdata=0.
  - Repeat with pready rising on the 4th cycle: normal completion, slverr=0.
